rggen_apb_bridge_arbiter: RTL and testbench

//   Shares a single APB slave port (the apb_if of a generated register block) between
//   NUM_REQUESTERS simple request/acknowledge masters, e.g. CPU, debug and DMA.

---
 rtl/rggen_apb_bridge_arbiter.sv | 137 +++++++++++++
 tb/tb_rggen_apb_bridge_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_apb_bridge_arbiter.sv
// rtl/rggen_apb_bridge_arbiter.sv - round-robin arbiter sharing one APB slave port between request/ack masters
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req[N]                   per-requester request, held until its o_ack
//   i_write[N]                 per-requester direction (1 = write)
//   i_address[N*AW]            requester k at [k*AW +: AW]
//   i_write_data[N*DW]         requester k at [k*DW +: DW]
//   o_ack[N]                   one-cycle completion pulse to the winner
//   o_error, o_read_data       pslverr / prdata of the completed transfer, valid with o_ack
//   o_psel, o_penable, o_pwrite, o_paddr, o_pwdata   APB master outputs (registered)
//   i_pready, i_prdata, i_pslverr                    APB slave responses
module rggen_apb_bridge_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQUESTERS-1:0]            i_req,
    input  logic [NUM_REQUESTERS-1:0]            i_write,
    input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    i_write_data,
    output logic [NUM_REQUESTERS-1:0]            o_ack,
    output logic                                 o_error,
    output logic [DATA_WIDTH-1:0]                o_read_data,
    output logic                                 o_psel,
    output logic                                 o_penable,
    output logic                                 o_pwrite,
    output logic [ADDRESS_WIDTH-1:0]             o_paddr,
    output logic [DATA_WIDTH-1:0]                o_pwdata,
    input  logic                                 i_pready,
    input  logic [DATA_WIDTH-1:0]                i_prdata,
    input  logic                                 i_pslverr
);

    localparam int N  = NUM_REQUESTERS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_GRANT_RESET = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant;
    logic [IW-1:0] winner;
    logic          found;
    int            cand;

    // Scan requesters starting one past the last winner; the first active
    // request found wins, so every requester waits at most N-1 transfers.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last_grant) + off) % N;
            if (!found && i_req[cand[IW-1:0]]) begin
                winner = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (i_pready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered datapath: every APB and requester-side output is a flop,
    // loaded on the edge that enters the state in which it must be visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= LAST_GRANT_RESET;
            grant       <= '0;
            o_ack       <= '0;
            o_error     <= 1'b0;
            o_read_data <= '0;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_paddr     <= '0;
            o_pwdata    <= '0;
        end else begin
            o_ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        // Latch the winner's command so later input changes
                        // cannot disturb the transfer in flight.
                        grant    <= winner;
                        o_pwrite <= i_write[winner];
                        o_paddr  <= i_address[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        o_pwdata <= i_write_data[winner*DATA_WIDTH +: DATA_WIDTH];
                        o_psel   <= 1'b1;
                    end
                end
                SETUP: begin
                    o_penable <= 1'b1;
                end
                ACCESS: begin
                    if (i_pready) begin
                        o_psel       <= 1'b0;
                        o_penable    <= 1'b0;
                        o_read_data  <= o_pwrite ? '0 : i_prdata;
                        o_error      <= i_pslverr;
                        last_grant   <= grant;
                        o_ack[grant] <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_apb_bridge_arbiter.sv
// tb/tb_rggen_apb_bridge_arbiter.sv - directed scoreboard bench for rggen_apb_bridge_arbiter
module tb_rggen_apb_bridge_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // N=2 instance
    logic [1:0]  req = '0;
    logic [1:0]  wr = '0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    // N=3 instance, slave always ready
    logic [2:0]  req3 = '0;
    logic [2:0]  wr3 = '0;
    logic [47:0] addr3 = '0;
    logic [95:0] wdata3 = '0;
    logic [2:0]  ack3;
    logic        err3;
    logic [31:0] rdata3;
    logic        psel3, penable3, pwrite3;
    logic [15:0] paddr3;
    logic [31:0] pwdata3;
    logic        pready3 = 1'b1;
    logic [31:0] prdata3 = 32'h3333_0000;
    logic        pslverr3 = 1'b0;

    int          checks = 0;
    int          failures = 0;

    int          slave_waits = 0;
    logic [31:0] slave_rdata = '0;
    logic        slave_err = 1'b0;
    int          slave_cnt = 0;

    typedef struct {
        logic [2:0]  ack_v;
        logic        err_v;
        logic [31:0] rd_v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rggen_apb_bridge_arbiter #(.NUM_REQUESTERS(2), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_write(wr), .i_address(addr),
        .i_write_data(wdata), .o_ack(ack), .o_error(err), .o_read_data(rdata),
        .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
        .o_pwdata(pwdata), .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr)
    );

    rggen_apb_bridge_arbiter #(.NUM_REQUESTERS(3), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_req(req3), .i_write(wr3), .i_address(addr3),
        .i_write_data(wdata3), .o_ack(ack3), .o_error(err3), .o_read_data(rdata3),
        .o_psel(psel3), .o_penable(penable3), .o_pwrite(pwrite3), .o_paddr(paddr3),
        .o_pwdata(pwdata3), .i_pready(pready3), .i_prdata(prdata3), .i_pslverr(pslverr3)
    );

    // APB slave: asserts pready after slave_waits wait cycles of ACCESS.
    initial begin
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (slave_cnt == slave_waits) begin
                    pready  = 1'b1;
                    prdata  = slave_rdata;
                    pslverr = slave_err;
                end else begin
                    pready  = 1'b0;
                    slave_cnt++;
                end
            end else begin
                pready    = 1'b0;
                pslverr   = 1'b0;
                slave_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic e, input logic [31:0] d);
        exp_t x;
        x.ack_v = a;
        x.err_v = e;
        x.rd_v  = d;
        sb.push_back(x);
    endtask

    task automatic score(input string tag, input logic [2:0] a, input logic e, input logic [31:0] d);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(a), 64'hFFFF);
        end else begin
            x = sb.pop_front();
            check({tag, "_ack"}, 64'(a), 64'(x.ack_v));
            check({tag, "_err"}, 64'(e), 64'(x.err_v));
            check({tag, "_rdata"}, 64'(d), 64'(x.rd_v));
        end
    endtask

    // Waits up to 30 cycles for an ack on the selected instance, then scores it.
    task automatic wait_score(input int sel, input string tag, output int cyc);
        logic [2:0]  a;
        logic        e;
        logic [31:0] d;
        a = '0;
        e = 1'b0;
        d = '0;
        cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            a = (sel != 0) ? ack3 : {1'b0, ack};
            e = (sel != 0) ? err3 : err;
            d = (sel != 0) ? rdata3 : rdata;
            cyc = i;
            if (a != '0) break;
        end
        score(tag, a, e, d);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;

        // Reset state
        step();
        step();
        check("rst_psel", 64'(psel), 64'h0);
        check("rst_penable", 64'(penable), 64'h0);
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_paddr_pwdata", {16'h0, paddr, pwdata}, 64'h0);
        check("rst_rdata_err", {31'h0, err, rdata}, 64'h0);
        rst_n = 1'b1;
        step();

        // 1. Single read, zero wait states
        slave_waits = 0;
        slave_rdata = 32'hDEAD_BEEF;
        slave_err   = 1'b0;
        addr[15:0]  = 16'h0004;
        wr[0]       = 1'b0;
        req[0]      = 1'b1;
        push(3'b001, 1'b0, 32'hDEAD_BEEF);
        step();
        check("t1_c1_setup", {psel, penable, pwrite}, 64'b100);
        check("t1_c1_paddr", 64'(paddr), 64'h0004);
        step();
        check("t1_c2_access", {psel, penable}, 64'b11);
        step();
        score("t1_c3", {1'b0, ack}, err, rdata);
        req[0] = 1'b0;
        step();
        check("t1_ack_pulse", 64'(ack), 64'h0);

        // 2 + 6. Write with 3 wait states; inputs change during SETUP/ACCESS
        slave_waits  = 3;
        slave_rdata  = 32'hA5A5_A5A5;
        addr[31:16]  = 16'h0010;
        wdata[63:32] = 32'h1234_5678;
        wr[1]        = 1'b1;
        req[1]       = 1'b1;
        push(3'b010, 1'b0, 32'h0);
        step();
        check("t2_c1_setup", {psel, penable, pwrite}, 64'b101);
        addr[31:16]  = 16'hBEEF;
        wdata[63:32] = 32'h0BAD_0BAD;
        for (int c = 2; c <= 5; c++) begin
            step();
            check($sformatf("t2_c%0d_access", c), {ack, psel, penable}, 64'b0011);
            check($sformatf("t2_c%0d_latched", c), {paddr, pwdata}, {16'h0010, 32'h1234_5678});
            addr[31:16]  = 16'(c);
            wdata[63:32] = 32'(c);
        end
        step();
        score("t2_c6", {1'b0, ack}, err, rdata);
        req[1] = 1'b0;
        wr[1]  = 1'b0;
        step();

        // 3. Round-robin, both held
        slave_waits = 0;
        slave_rdata = 32'h0000_1111;
        addr        = {16'h0200, 16'h0100};
        req         = 2'b11;
        push(3'b001, 1'b0, 32'h1111);
        push(3'b010, 1'b0, 32'h1111);
        push(3'b001, 1'b0, 32'h1111);
        push(3'b010, 1'b0, 32'h1111);
        wait_score(0, "t3_rr0", cyc);
        check("t3_lat0", 64'(cyc), 64'd3);
        for (int k = 1; k < 4; k++) begin
            wait_score(0, $sformatf("t3_rr%0d", k), cyc);
            check($sformatf("t3_gap%0d", k), 64'(cyc), 64'd4);
        end
        req = 2'b00;
        step();

        // 4. Slave error on read of 0x00FC
        slave_rdata = 32'hCAFE_F00D;
        slave_err   = 1'b1;
        addr[15:0]  = 16'h00FC;
        req[0]      = 1'b1;
        push(3'b001, 1'b1, 32'hCAFE_F00D);
        wait_score(0, "t4_slverr", cyc);
        check("t4_lat", 64'(cyc), 64'd3);
        req[0]    = 1'b0;
        slave_err = 1'b0;
        step();

        // 5. Reset during an ACCESS wait state
        slave_waits = 5;
        addr[31:16] = 16'h0020;
        req[1]      = 1'b1;
        step();
        step();
        step();
        check("t5_in_access", {psel, penable}, 64'b11);
        rst_n = 1'b0;
        #1;
        check("t5_async_drop", {psel, penable}, 64'b00);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("t5_no_ack%0d", k), 64'(ack), 64'h0);
        end
        slave_waits = 0;
        slave_rdata = 32'h5555_AAAA;
        rst_n = 1'b1;
        push(3'b010, 1'b0, 32'h5555_AAAA);
        push(3'b001, 1'b0, 32'h5555_AAAA);
        step();
        check("t5_regrant", {psel, penable, paddr}, {2'b10, 16'h0020});
        req[0] = 1'b1;
        wait_score(0, "t5_first", cyc);
        req[1] = 1'b0;
        wait_score(0, "t5_second", cyc);
        req[0] = 1'b0;
        step();

        // 3b. N=3 round-robin, all held
        req3 = 3'b111;
        push(3'b001, 1'b0, 32'h3333_0000);
        push(3'b010, 1'b0, 32'h3333_0000);
        push(3'b100, 1'b0, 32'h3333_0000);
        push(3'b001, 1'b0, 32'h3333_0000);
        wait_score(1, "n3_rr0", cyc);
        for (int k = 1; k < 4; k++) begin
            wait_score(1, $sformatf("n3_rr%0d", k), cyc);
            check($sformatf("n3_gap%0d", k), 64'(cyc), 64'd4);
        end
        req3 = 3'b000;
        step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
